// File: rtl/cache_perf_reporter.sv
// cache_perf_reporter: counts rising edges on NUM_CH cache event strobes and,
// every PERIOD cycles, snapshots all counters and streams them to a UART TX
// FIFO as an ASCII frame "a<hex>b<hex>...\r\n", one byte per write strobe.
//
// Handshake: wr_en_o is a registered strobe; each high cycle is exactly one
// byte written into the FIFO with data_o. A byte is issued only when
// fifo_full_i is low in the cycle before it appears; while full the frame
// position holds and no byte is skipped.
module cache_perf_reporter #(
    parameter int NUM_CH      = 8,
    parameter int CNT_W       = 12,
    parameter int PERIOD      = 300,
    parameter int CLR_ON_SNAP = 0,
    parameter int SATURATE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              fifo_full_i,
    output logic [7:0]        data_o,
    output logic              wr_en_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic [7:0]        overrun_cnt_o
);

    localparam int NIB   = CNT_W / 4;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int TMR_W = $clog2(PERIOD);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIB - 1);
    localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(PERIOD - 1);

    // The state names the byte currently on data_o (or still waiting to go).
    typedef enum logic [2:0] {S_IDLE, S_TAG, S_DIGIT, S_CR, S_LF} state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_ch;
    logic [NIB_W-1:0]  r_nib;
    logic [7:0]        r_data;
    logic              r_wr_en;
    logic [TMR_W-1:0]  r_timer;
    logic [NUM_CH-1:0] r_prev;
    logic [CNT_W-1:0]  r_cnt  [NUM_CH];
    logic [CNT_W-1:0]  r_snap [NUM_CH];
    logic              r_overrun;
    logic [7:0]        r_ovr_cnt;

    logic              w_tick;
    logic              w_accept;
    logic              w_drop;
    logic [NUM_CH-1:0] w_inc;
    state_t            w_adv_state;
    logic [CH_W-1:0]   w_adv_ch;
    logic [NIB_W-1:0]  w_adv_nib;
    logic              w_move;
    state_t            w_tgt_state;
    logic [CH_W-1:0]   w_tgt_ch;
    logic [NIB_W-1:0]  w_tgt_nib;
    logic [NIB_W-1:0]  w_nib_sel;
    logic [CNT_W-1:0]  w_snap_sh;
    logic [3:0]        w_nibble;
    logic [7:0]        w_byte;

    assign w_tick   = (r_timer == LAST_TMR);
    assign w_accept = w_tick & (r_state == S_IDLE);
    assign w_drop   = w_tick & (r_state != S_IDLE);
    assign w_inc    = event_i & ~r_prev & {NUM_CH{en_i}};

    assign data_o        = r_data;
    assign wr_en_o       = r_wr_en;
    assign busy_o        = (r_state != S_IDLE);
    assign overrun_o     = r_overrun;
    assign overrun_cnt_o = r_ovr_cnt;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if ((SATURATE != 0) && (&v)) return v;
        return v + CNT_W'(1);
    endfunction

    // Free-running snapshot interval timer, 0..PERIOD-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_timer <= '0;
        else if (w_tick) r_timer <= '0;
        else r_timer <= r_timer + TMR_W'(1);
    end

    // Edge detect, event counters and snapshot capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_cnt[k]  <= '0;
                r_snap[k] <= '0;
            end
        end else begin
            r_prev <= event_i;
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_accept) begin
                    r_snap[k] <= r_cnt[k];
                    // A same-cycle edge restarts the count at 1 so it is not lost.
                    if (CLR_ON_SNAP != 0) r_cnt[k] <= w_inc[k] ? CNT_W'(1) : '0;
                    else if (w_inc[k]) r_cnt[k] <= bump(r_cnt[k]);
                end else if (w_inc[k]) begin
                    r_cnt[k] <= bump(r_cnt[k]);
                end
            end
        end
    end

    // Sticky overrun flag and saturating dropped-snapshot counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    // Next frame position: advance once the current byte is written,
    // otherwise retry the same byte.
    always_comb begin
        w_adv_state = r_state;
        w_adv_ch    = r_ch;
        w_adv_nib   = r_nib;
        case (r_state)
            S_IDLE: begin
                w_adv_state = S_TAG;
                w_adv_ch    = '0;
                w_adv_nib   = '0;
            end
            S_TAG: begin
                w_adv_state = S_DIGIT;
                w_adv_nib   = '0;
            end
            S_DIGIT: begin
                if (r_nib == LAST_NIB) begin
                    w_adv_nib = '0;
                    if (r_ch == LAST_CH) begin
                        w_adv_state = S_CR;
                    end else begin
                        w_adv_state = S_TAG;
                        w_adv_ch    = r_ch + CH_W'(1);
                    end
                end else begin
                    w_adv_nib = r_nib + NIB_W'(1);
                end
            end
            S_CR:    w_adv_state = S_LF;
            S_LF:    w_adv_state = S_IDLE;
            default: w_adv_state = S_IDLE;
        endcase
        w_move      = (r_state == S_IDLE) ? w_tick : r_wr_en;
        w_tgt_state = w_move ? w_adv_state : r_state;
        w_tgt_ch    = w_move ? w_adv_ch : r_ch;
        w_tgt_nib   = w_move ? w_adv_nib : r_nib;
    end

    // ASCII byte for the target frame position; digits MS nibble first.
    always_comb begin
        w_nib_sel = LAST_NIB - w_tgt_nib;
        w_snap_sh = r_snap[w_tgt_ch] >> {w_nib_sel, 2'b00};
        w_nibble  = w_snap_sh[3:0];
        w_byte    = 8'h00;
        case (w_tgt_state)
            S_TAG:   w_byte = 8'h61 + 8'(w_tgt_ch);
            S_DIGIT: w_byte = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                                 : (8'h37 + {4'h0, w_nibble});
            S_CR:    w_byte = 8'h0D;
            S_LF:    w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end

    // Frame state and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_nib   <= '0;
            r_data  <= '0;
            r_wr_en <= 1'b0;
        end else begin
            r_state <= w_tgt_state;
            r_ch    <= w_tgt_ch;
            r_nib   <= w_tgt_nib;
            r_wr_en <= (w_tgt_state != S_IDLE) & ~fifo_full_i;
            if ((w_tgt_state != S_IDLE) && !fifo_full_i) r_data <= w_byte;
        end
    end

endmodule

// File: tb/tb_cache_perf_reporter.sv
// Bench for cache_perf_reporter: five parameter sets share one input bundle;
// a select picks which instance's outputs are observed.
module tb_cache_perf_reporter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_i = 1'b1;
    logic [1:0] ev = 2'b00;
    logic       full = 1'b0;

    logic [7:0] data_w [5];
    logic       wr_w   [5];
    logic       busy_w [5];
    logic       ovr_w  [5];
    logic [7:0] ocnt_w [5];

    always #5 clk = ~clk;

    // 0: basic 8-bit, period 50
    cache_perf_reporter #(.NUM_CH(2), .CNT_W(8), .PERIOD(50), .CLR_ON_SNAP(0), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .en_i(en_i), .event_i(ev), .fifo_full_i(full),
        .data_o(data_w[0]), .wr_en_o(wr_w[0]), .busy_o(busy_w[0]),
        .overrun_o(ovr_w[0]), .overrun_cnt_o(ocnt_w[0]));
    // 1: period shorter than the frame
    cache_perf_reporter #(.NUM_CH(2), .CNT_W(8), .PERIOD(6), .CLR_ON_SNAP(0), .SATURATE(0)) u_b (
        .clk(clk), .rst(rst), .en_i(en_i), .event_i(ev), .fifo_full_i(full),
        .data_o(data_w[1]), .wr_en_o(wr_w[1]), .busy_o(busy_w[1]),
        .overrun_o(ovr_w[1]), .overrun_cnt_o(ocnt_w[1]));
    // 2: 4-bit saturating
    cache_perf_reporter #(.NUM_CH(2), .CNT_W(4), .PERIOD(40), .CLR_ON_SNAP(0), .SATURATE(1)) u_c (
        .clk(clk), .rst(rst), .en_i(en_i), .event_i(ev), .fifo_full_i(full),
        .data_o(data_w[2]), .wr_en_o(wr_w[2]), .busy_o(busy_w[2]),
        .overrun_o(ovr_w[2]), .overrun_cnt_o(ocnt_w[2]));
    // 3: 4-bit wrapping
    cache_perf_reporter #(.NUM_CH(2), .CNT_W(4), .PERIOD(40), .CLR_ON_SNAP(0), .SATURATE(0)) u_d (
        .clk(clk), .rst(rst), .en_i(en_i), .event_i(ev), .fifo_full_i(full),
        .data_o(data_w[3]), .wr_en_o(wr_w[3]), .busy_o(busy_w[3]),
        .overrun_o(ovr_w[3]), .overrun_cnt_o(ocnt_w[3]));
    // 4: clear on snapshot
    cache_perf_reporter #(.NUM_CH(2), .CNT_W(8), .PERIOD(50), .CLR_ON_SNAP(1), .SATURATE(0)) u_e (
        .clk(clk), .rst(rst), .en_i(en_i), .event_i(ev), .fifo_full_i(full),
        .data_o(data_w[4]), .wr_en_o(wr_w[4]), .busy_o(busy_w[4]),
        .overrun_o(ovr_w[4]), .overrun_cnt_o(ocnt_w[4]));

    logic [2:0] sel = 3'd0;
    logic [7:0] m_data;
    logic       m_wr, m_busy, m_ovr;
    logic [7:0] m_ocnt;

    always_comb begin
        m_data = data_w[sel];
        m_wr   = wr_w[sel];
        m_busy = busy_w[sel];
        m_ovr  = ovr_w[sel];
        m_ocnt = ocnt_w[sel];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int t0 = 0;

    logic [63:0] got_frame;
    int got_n, first_k, last_k, busy_len;

    typedef struct {
        logic [2:0]  sel;
        int          n0;
        int          n1;
        int          period;
        int          len;
        logic [63:0] frame;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Clock/reset: release between edges; edge k after release has cyc-t0 == k.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ev = 2'b00; full = 1'b0; en_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
    endtask

    // Driver: n0/n1 single-cycle pulses, one rising edge every two clocks.
    task automatic pulse(input int n0, input int n1);
        int m;
        m = (n0 > n1) ? n0 : n1;
        for (int i = 0; i < m; i++) begin
            @(negedge clk);
            ev[0] = (i < n0);
            ev[1] = (i < n1);
            @(negedge clk);
            ev = 2'b00;
        end
    endtask

    // Monitor: gather written bytes until busy falls (or stop_at bytes).
    // stall_after > 0 holds fifo full for 5 cycles once that many bytes arrived.
    task automatic collect(input int budget, input int stop_at, input int stall_after);
        int   stall_left;
        logic seen_busy;
        got_frame = '0; got_n = 0; first_k = -1; last_k = -1; busy_len = 0;
        stall_left = 0; seen_busy = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) full = 1'b0;
            end
            if (m_busy) begin
                seen_busy = 1'b1;
                busy_len++;
            end
            if (m_wr) begin
                got_frame = {got_frame[55:0], m_data};
                if (got_n == 0) first_k = cyc - t0;
                last_k = cyc - t0;
                got_n++;
                if (got_n == stall_after) begin
                    full = 1'b1;
                    stall_left = 5;
                end
                if (got_n == stop_at) return;
            end
            if (seen_busy && !m_busy) return;
        end
        checks++;
        failures++;
        full = 1'b0;
        $display("FAIL collect_timeout bytes=%0d required=frame end", got_n);
    endtask

    initial begin
        vecs[0] = '{3'd0, 10,  3, 50, 8, 64'h6130_4162_3033_0D0A}; // a0Ab03
        vecs[1] = '{3'd0,  0,  0, 50, 8, 64'h6130_3062_3030_0D0A}; // a00b00
        vecs[2] = '{3'd0, 15, 20, 50, 8, 64'h6130_4662_3134_0D0A}; // a0Fb14
        vecs[3] = '{3'd2, 17,  2, 40, 6, 64'h0000_6146_6232_0D0A}; // aFb2 sat
        vecs[4] = '{3'd3, 17,  2, 40, 6, 64'h0000_6131_6232_0D0A}; // a1b2 wrap
        vecs[5] = '{3'd2, 15,  0, 40, 6, 64'h0000_6146_6230_0D0A}; // aFb0
        vecs[6] = '{3'd3, 16,  0, 40, 6, 64'h0000_6130_6230_0D0A}; // a0b0

        // Reset state
        sel = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_data", 64'(m_data), 64'h0);
        chk("rst_wr_en", 64'(m_wr), 64'h0);
        chk("rst_busy", 64'(m_busy), 64'h0);
        chk("rst_overrun", 64'(m_ovr), 64'h0);
        chk("rst_overrun_cnt", 64'(m_ocnt), 64'h0);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].sel;
            do_reset();
            pulse(vecs[v].n0, vecs[v].n1);
            collect(200, 0, 0);
            chk($sformatf("v%0d_frame", v), got_frame, vecs[v].frame);
            chk($sformatf("v%0d_len", v), 64'(got_n), 64'(vecs[v].len));
            chk($sformatf("v%0d_first_cycle", v), 64'(first_k), 64'(vecs[v].period));
            chk($sformatf("v%0d_gaps", v), 64'(last_k - first_k + 1 - got_n), 64'h0);
        end

        // Backpressure: 5 full cycles after byte 3
        sel = 3'd0;
        do_reset();
        pulse(10, 3);
        collect(200, 0, 3);
        chk("bp_frame", got_frame, 64'h6130_4162_3033_0D0A);
        chk("bp_len", 64'(got_n), 64'd8);
        chk("bp_first_cycle", 64'(first_k), 64'd50);
        chk("bp_gaps", 64'(last_k - first_k + 1 - got_n), 64'd5);
        chk("bp_busy_len", 64'(busy_len), 64'd13);

        // Overrun: PERIOD 6 against an 8-byte frame
        sel = 3'd1;
        do_reset();
        pulse(1, 2);
        collect(40, 0, 0);
        chk("ovr_frame1", got_frame, 64'h6130_3162_3032_0D0A);
        chk("ovr_first1", 64'(first_k), 64'd6);
        chk("ovr_flag1", 64'(m_ovr), 64'd1);
        chk("ovr_cnt1", 64'(m_ocnt), 64'd1);
        pulse(2, 1);
        collect(40, 0, 0);
        chk("ovr_frame2", got_frame, 64'h6130_3362_3033_0D0A);
        chk("ovr_first2", 64'(first_k), 64'd18);
        chk("ovr_cnt2", 64'(m_ocnt), 64'd2);

        // Clear-on-snapshot with an edge in the tick cycle
        sel = 3'd4;
        do_reset();
        pulse(5, 0);
        while (cyc - t0 < 49) @(negedge clk);
        ev[0] = 1'b1;
        collect(40, 0, 0);
        chk("clr_frame1", got_frame, 64'h6130_3562_3030_0D0A);
        chk("clr_first1", 64'(first_k), 64'd50);
        @(negedge clk);
        ev = 2'b00;
        pulse(2, 0);
        collect(100, 0, 0);
        chk("clr_frame2", got_frame, 64'h6130_3362_3030_0D0A);
        chk("clr_first2", 64'(first_k), 64'd100);
        chk("clr_no_overrun", 64'(m_ovr), 64'd0);

        // Async reset during byte 4
        sel = 3'd0;
        do_reset();
        pulse(10, 3);
        collect(200, 4, 0);
        chk("ar_bytes_before", 64'(got_n), 64'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_wr_en", 64'(m_wr), 64'd0);
        chk("ar_busy", 64'(m_busy), 64'd0);
        do_reset();
        collect(200, 0, 0);
        chk("ar_frame", got_frame, 64'h6130_3062_3030_0D0A);
        chk("ar_first", 64'(first_k), 64'd50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
